// File: rtl/pipe_control_unit.sv
// Pipelined control decoder for the 16-bit, 4-bit-opcode ISA.
// Decodes in ID, carries control through EX/MEM/WB, detects load-use.
module pipe_control_unit #(
  parameter int REG_ADDR_W = 4,
  parameter bit HAZARD_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [3:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src1_en,
  input  logic                  id_src2_en,
  input  logic                  flush_id,
  input  logic                  pipe_hold,
  output logic [1:0]            id_branch,
  output logic                  stall,
  output logic                  ex_valid,
  output logic                  ex_alu_src,
  output logic                  ex_load_byte,
  output logic                  ex_pcs,
  output logic                  mem_valid,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  halt_pending,
  output logic                  halted
);

  typedef struct packed {
    logic reg_write;
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic load_byte;
    logic pcs;
    logic halt;
  } ctl_t;

  ctl_t                  dec;
  ctl_t                  ex_ctl;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mem_reg_write;
  logic                  mem_mem_to_reg;
  logic                  mem_halt;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  hazard;
  logic                  load_id;

  always_comb begin
    dec       = '0;
    id_branch = 2'b00;
    unique case (1'b1)
      (!id_opcode[3]): begin
        dec.reg_write = 1'b1;
        dec.alu_src   = (id_opcode[2:0] >= 3'd4) &&
                        (id_opcode[2:0] != 3'd7);
      end
      (id_opcode == 4'h8): begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
      end
      (id_opcode == 4'h9): begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      (id_opcode == 4'hA),
      (id_opcode == 4'hB): begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.load_byte = 1'b1;
      end
      (id_opcode == 4'hC): id_branch = 2'b11;
      (id_opcode == 4'hD): id_branch = 2'b10;
      (id_opcode == 4'hE): begin
        dec.pcs       = 1'b1;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      (id_opcode == 4'hF): dec.halt = 1'b1;
      default: ;
    endcase
    // r0 is hardwired, so a write to it is dropped at decode
    if (id_rd == '0) dec.reg_write = 1'b0;
  end

  assign hazard = id_valid & ex_valid & ex_ctl.mem_read &
                  (ex_rd != '0) &
                  ((id_src1_en & (id_src1 == ex_rd)) |
                   (id_src2_en & (id_src2 == ex_rd)));
  assign stall   = HAZARD_EN ? hazard : 1'b0;
  assign load_id = id_valid & ~stall & ~flush_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid       <= 1'b0;
      ex_ctl         <= '0;
      ex_rd          <= '0;
      mem_valid      <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_halt       <= 1'b0;
      mem_rd         <= '0;
      wb_valid       <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
      wb_rd          <= '0;
      halt_pending   <= 1'b0;
      halted         <= 1'b0;
    end else if (!pipe_hold) begin
      ex_valid       <= load_id;
      ex_ctl         <= load_id ? dec : '0;
      ex_rd          <= load_id ? id_rd : '0;
      mem_valid      <= ex_valid;
      mem_read       <= ex_valid & ex_ctl.mem_read;
      mem_write      <= ex_valid & ex_ctl.mem_write;
      mem_reg_write  <= ex_valid & ex_ctl.reg_write;
      mem_mem_to_reg <= ex_valid & ex_ctl.mem_to_reg;
      mem_halt       <= ex_valid & ex_ctl.halt;
      mem_rd         <= ex_rd;
      wb_valid       <= mem_valid;
      wb_reg_write   <= mem_valid & mem_reg_write;
      wb_mem_to_reg  <= mem_valid & mem_mem_to_reg;
      wb_rd          <= mem_rd;
      halt_pending   <= halt_pending | (load_id & dec.halt);
      halted         <= halted | (mem_valid & mem_halt);
    end
  end

  assign ex_alu_src   = ex_ctl.alu_src;
  assign ex_load_byte = ex_ctl.load_byte;
  assign ex_pcs       = ex_ctl.pcs;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: stimulus pushes expected
// stage bundles, a negedge monitor pops them as each stage goes valid.
module tb_pipe_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [3:0] id_opcode = '0;
  logic [3:0] id_rd = '0;
  logic [3:0] id_src1 = '0;
  logic [3:0] id_src2 = '0;
  logic       id_src1_en = 1'b0;
  logic       id_src2_en = 1'b0;
  logic       flush_id = 1'b0;
  logic       pipe_hold = 1'b0;
  logic [1:0] id_branch;
  logic       stall;
  logic       ex_valid, ex_alu_src, ex_load_byte, ex_pcs;
  logic       mem_valid, mem_read, mem_write;
  logic       wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [3:0] wb_rd;
  logic       halt_pending, halted;

  int n_cmp = 0;
  int n_bad = 0;
  logic adv = 1'b0;
  logic [2:0] ex_q[$];
  logic [1:0] mem_q[$];
  logic [5:0] wb_q[$];
  // {rw, alu, mr, mw, m2r, lb, pcs, halt, branch[1:0]}
  logic [9:0] dtab [16];

  always #5 clk = ~clk;

  pipe_control_unit #(.REG_ADDR_W(4), .HAZARD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rd(id_rd), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_en(id_src1_en), .id_src2_en(id_src2_en),
    .flush_id(flush_id), .pipe_hold(pipe_hold),
    .id_branch(id_branch), .stall(stall),
    .ex_valid(ex_valid), .ex_alu_src(ex_alu_src),
    .ex_load_byte(ex_load_byte), .ex_pcs(ex_pcs),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
    .halt_pending(halt_pending), .halted(halted)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) adv <= rst | ~pipe_hold;

  always @(negedge clk) begin
    logic [2:0] e3;
    logic [1:0] e2;
    logic [5:0] e6;
    if (adv) begin
      if (ex_valid) begin
        if (ex_q.size() == 0) chk("ex_unexpected", 1, 0);
        else begin
          e3 = ex_q.pop_front();
          chk("ex_ctl", {ex_alu_src, ex_load_byte, ex_pcs}, e3);
        end
      end else chk("ex_bubble", {ex_alu_src, ex_load_byte, ex_pcs}, 0);
      if (mem_valid) begin
        if (mem_q.size() == 0) chk("mem_unexpected", 1, 0);
        else begin
          e2 = mem_q.pop_front();
          chk("mem_ctl", {mem_read, mem_write}, e2);
        end
      end else chk("mem_bubble", {mem_read, mem_write}, 0);
      if (wb_valid) begin
        if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
        else begin
          e6 = wb_q.pop_front();
          chk("wb_ctl", {wb_rd, wb_reg_write, wb_mem_to_reg}, e6);
        end
      end else chk("wb_bubble", {wb_reg_write, wb_mem_to_reg}, 0);
    end
  end

  task automatic cyc(input logic v, input logic [3:0] op, rd, s1,
                     input logic s1e, input logic [3:0] s2,
                     input logic s2e, fl, hold, exp_stall);
    logic [9:0] d;
    id_valid = v; id_opcode = op; id_rd = rd;
    id_src1 = s1; id_src1_en = s1e;
    id_src2 = s2; id_src2_en = s2e;
    flush_id = fl; pipe_hold = hold;
    d = dtab[op];
    @(negedge clk);
    chk("stall", stall, exp_stall);
    chk("id_branch", id_branch, d[1:0]);
    if (v && !exp_stall && !fl && !hold) begin
      ex_q.push_back({d[8], d[4], d[3]});
      mem_q.push_back({d[7], d[6]});
      wb_q.push_back({rd, d[9] & (rd != 4'd0), d[5]});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input logic hold);
    rst = 1'b1; pipe_hold = hold;
    id_valid = 1'b0; flush_id = 1'b0;
    @(posedge clk); #1;
    ex_q.delete(); mem_q.delete(); wb_q.delete();
    @(negedge clk);
    chk("reset_outputs",
        {ex_valid, ex_alu_src, ex_load_byte, ex_pcs, mem_valid, mem_read,
         mem_write, wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd,
         halt_pending, halted}, 0);
    rst = 1'b0; pipe_hold = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    dtab[0]  = 10'b1000000000;
    dtab[1]  = 10'b1000000000;
    dtab[2]  = 10'b1000000000;
    dtab[3]  = 10'b1000000000;
    dtab[4]  = 10'b1100000000;
    dtab[5]  = 10'b1100000000;
    dtab[6]  = 10'b1100000000;
    dtab[7]  = 10'b1000000000;
    dtab[8]  = 10'b1110100000;
    dtab[9]  = 10'b0101000000;
    dtab[10] = 10'b1100010000;
    dtab[11] = 10'b1100010000;
    dtab[12] = 10'b0000000011;
    dtab[13] = 10'b0000000010;
    dtab[14] = 10'b1100001000;
    dtab[15] = 10'b0000000100;

    repeat (2) @(posedge clk);
    #1;
    do_reset(0);

    // decode sweep, HLT last
    for (int i = 0; i < 16; i++) cyc(1, 4'(i), 4'd5, 0, 0, 0, 0, 0, 0, 0);
    chk("sweep_halt_pending", halt_pending, 1);
    chk("sweep_halted_early", halted, 0);
    idle(1);
    chk("sweep_halted_n1", halted, 0);
    idle(1);
    chk("sweep_halted_n2", halted, 1);
    idle(2);
    do_reset(0);

    // load-use on src1
    cyc(1, 4'h8, 4'd3, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 4'h0, 4'd7, 4'd3, 1, 0, 0, 0, 0, 1);
    chk("stall_bubble", ex_valid, 0);
    cyc(1, 4'h0, 4'd7, 4'd3, 1, 0, 0, 0, 0, 0);
    // r0 destination never stalls
    cyc(1, 4'h8, 4'd0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 4'h0, 4'd8, 4'd0, 1, 0, 0, 0, 0, 0);
    // load-use on src2
    cyc(1, 4'h8, 4'd4, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 4'h1, 4'd9, 0, 0, 4'd4, 1, 0, 0, 1);
    cyc(1, 4'h1, 4'd9, 0, 0, 4'd4, 1, 0, 0, 0);
    // matching but disabled sources
    cyc(1, 4'h8, 4'd6, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 4'h2, 4'd10, 4'd6, 0, 4'd6, 0, 0, 0, 0);
    idle(4);

    // flushed SW
    cyc(1, 4'h9, 4'd0, 4'd1, 1, 4'd2, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("flush_no_write", {ex_valid, mem_valid, mem_write, wb_valid}, 0);
    end
    // flush and stall together: one bubble
    cyc(1, 4'h8, 4'd2, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 4'h0, 4'd3, 4'd2, 1, 0, 0, 1, 0, 1);
    chk("flush_stall_bubble", ex_valid, 0);
    cyc(1, 4'h1, 4'd4, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_stall_resume", ex_valid, 1);
    idle(4);

    // halt timing
    cyc(1, 4'h0, 4'd9, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 4'hF, 4'd0, 0, 0, 0, 0, 0, 0, 0);
    chk("halt_pending_n", halt_pending, 1);
    chk("halted_n", halted, 0);
    idle(1);
    chk("halted_n1", halted, 0);
    idle(1);
    chk("halted_n2", halted, 1);
    idle(1);
    do_reset(0);
    cyc(1, 4'hF, 4'd0, 0, 0, 0, 0, 1, 0, 0);
    idle(4);
    chk("flushed_hlt_flags", {halt_pending, halted}, 0);

    // 3-cycle hold with LW in EX
    cyc(1, 4'h8, 4'd10, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 4'h1, 4'd11, 0, 0, 0, 0, 0, 1, 0);
      chk("hold_frozen", {ex_valid, ex_alu_src, mem_valid, wb_valid},
          4'b1100);
    end
    cyc(1, 4'h1, 4'd11, 0, 0, 0, 0, 0, 0, 0);
    chk("hold_resume_mem", {ex_valid, mem_valid, mem_read}, 3'b111);
    idle(1);
    chk("hold_resume_wb", {wb_valid, wb_mem_to_reg, wb_rd}, 6'b11_1010);
    idle(3);

    // reset with full pipe, halted set, and hold asserted
    cyc(1, 4'hF, 4'd0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 4'h0, 4'd1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 4'h0, 4'd2, 0, 0, 0, 0, 0, 0, 0);
    chk("full_before_reset",
        {ex_valid, mem_valid, wb_valid, halt_pending, halted}, 5'b11111);
    do_reset(1);
    idle(3);

    chk("ex_q_drained", ex_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);
    chk("wb_q_drained", wb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Pipelined successor to the single-cycle control decoder for the 16-bit, 4-bit-opcode ISA. Decodes the opcode in ID, then carries the control bits through ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards, inserts bubbles on stall or flush, and tracks HLT to a sticky `halted` flag. Sits between the IF/ID register and the datapath stage registers of the pipelined CPU.

## Interface
- `REG_ADDR_W`, default 4: register-specifier width.
- `HAZARD_EN`, default 1: 1 enables load-use detection; 0 ties `stall` low.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: the ID-stage instruction is real, not a bubble.
- `id_opcode` in 4: opcode bits [15:12].
- `id_rd` in REG_ADDR_W: destination specifier.
- `id_src1`, `id_src2` in REG_ADDR_W: source specifiers read by this instruction.
- `id_src1_en`, `id_src2_en` in 1: the matching source is actually read.
- `flush_id` in 1: a taken branch was resolved; kill the ID instruction.
- `pipe_hold` in 1: global freeze, e.g. memory busy.
- `id_branch` out 2: combinational decode. 11 = B, 10 = BR, 00 = none.
- `stall` out 1: combinational load-use stall. Freezes PC and IF/ID.
- `ex_valid`, `ex_alu_src`, `ex_load_byte`, `ex_pcs` out 1: ID/EX control.
- `mem_valid`, `mem_read`, `mem_write` out 1: EX/MEM control.
- `wb_valid`, `wb_reg_write`, `wb_mem_to_reg` out 1: MEM/WB control.
- `wb_rd` out REG_ADDR_W: MEM/WB destination.
- `halt_pending` out 1: sticky; a HLT has entered EX. Fetch must stop.
- `halted` out 1: sticky; a HLT has reached WB.

## Operation
- **Decode, opcodes 0x0–0x7 (ALU):** reg_write=1. `alu_src`=1 only for 0x4–0x6 (SLL/SRA/ROR).
- **0x8 LW:** mem_read, mem_to_reg, alu_src, reg_write.
- **0x9 SW:** alu_src, mem_write.
- **0xA/0xB LLB/LHB:** alu_src, reg_write, load_byte.
- **0xC B:** branch=11. **0xD BR:** branch=10.
- **0xE PCS:** pcs, alu_src, reg_write.
- **0xF HLT:** halt, no other bits. All 16 opcodes are legal.
- **Load-use hazard:** `stall` = HAZARD_EN & id_valid & ex_valid & ex-stage mem_read & (ex_rd != 0) & ((id_src1_en & id_src1==ex_rd) | (id_src2_en & id_src2==ex_rd)).
  - ex_rd is internal, carried with ex_valid.
- **Register 0:** never causes a stall. `wb_reg_write` is forced to 0 when the destination is 0.
- **ID/EX load:** takes the decoded word when id_valid & !stall & !flush_id. Otherwise it takes a bubble: all control bits 0, valid 0.
- **Stall and flush together:** a bubble, as for either alone.
- **EX/MEM and MEM/WB:** copy the previous stage unconditionally. A control bit never survives with valid=0; the bits are ANDed with valid on capture.
- **pipe_hold=1:** every stage register and both sticky flags hold. `stall` and `id_branch` still evaluate combinationally.
- **HLT:** `halt_pending` sets when a valid HLT is captured into ID/EX. `halted` sets when that HLT is captured into MEM/WB.
  - A HLT killed by `flush_id` or `stall` never sets either flag.
  - Instructions already ahead of the HLT drain normally.
  - Both flags clear only on `rst`.

## Timing
- Decode, `id_branch` and `stall` are combinational in the ID cycle.
- An instruction accepted at edge N appears at ex_* after N, mem_* after N+1, wb_* after N+2, with no hold.
- Each hold cycle adds one cycle of latency at every stage.
- `halt_pending` rises with ex_valid for the HLT. `halted` rises two cycles later.
- **Reset:** all valid/control outputs are 0, `wb_rd`=0, `halt_pending`=0, `halted`=0. This applies on the first edge with rst=1.
- **Reset mid-operation:** all in-flight instructions are discarded. Reset overrides `pipe_hold`.
- A stall lasts exactly one cycle per load-use pair. The next cycle sees a bubble in EX, so `stall` drops.

## Test plan
- **Decode sweep:** opcodes 0x0–0xF, one per cycle, sources disabled. Each ex_* bit matches the decode list one cycle later. 0xC/0xD give `id_branch` 11/10 in the same cycle.
- **Load-use:** LW rd=3, then ADD src1=3, src1_en=1. `stall`=1 for exactly one cycle and ex_valid=0 the next cycle. ADD reaches WB with wb_rd as given and wb_reg_write=1. Repeat with rd=0: no stall.
- **Flush:** `flush_id`=1 with a valid SW in ID. mem_write stays 0 in all stages. Flush plus stall in the same cycle gives a single bubble.
- **Halt:** HLT accepted at edge N. `halt_pending`=1 after N, `halted`=1 after N+2, and an ADD issued before it completes WB. A HLT flushed in ID leaves both flags 0.
- **Hold:** 3-cycle `pipe_hold` with LW in EX. All stage outputs are frozen, then resume with correct +3-cycle latency.
- **Reset:** `rst` asserted with a full pipeline and `halted`=1. All outputs are 0 after one edge, even with `pipe_hold`=1.
